tag_issue_buffer: RTL
=====================

# tag_issue_buffer

Upstream feeder for the multibit-tree tag sorter's input register stage. Buffers 12-bit tags arriving from the tag-computation logic in a small FIFO and issues them one at a time to the input register as a one-cycle `ena` pulse with the tag alongside. After each issue it waits for the tree to report completion. This decouples bursty tag arrival from the tree's multi-cycle insertion.

## Interface
- `TAG_W`, 12: tag width; must match the input register's tag width.
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `ADDR_W`, 3: log2(`DEPTH`).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous and active-low.
- `tag_valid`  in  1  upstream presents a tag this cycle.
- `tag_in`  in  TAG_W  tag value; sampled only when `tag_valid` is high.
- `tag_ready`  out  1  combinational; equals `!full`.
- `tree_done`  in  1  pulse from the tree controller; the current insertion is finished.
- `ena`  out  1  registered one-cycle issue strobe to the input register.
- `incoming_tag`  out  TAG_W  registered tag accompanying `ena`; holds its value between issues.
- `busy`  out  1  registered; high while an issued tag awaits `tree_done`.
- `count`  out  ADDR_W+1  registered FIFO occupancy, 0 to `DEPTH`.
- `overflow`  out  1  sticky; set when a tag arrives while full; cleared only by reset.

## Operation
- FIFO storage:
  - `DEPTH` x `TAG_W` register array.
  - Write pointer `wr_ptr` and read pointer `rd_ptr`, each `ADDR_W` bits, wrapping modulo `DEPTH`.
  - `full` is `count == DEPTH`; `empty` is `count == 0`.
- Push: `tag_valid && !full` at an edge writes `tag_in` to `mem[wr_ptr]` and increments `wr_ptr`.
- Push while full: `tag_valid && full` drops the tag, sets `overflow`, and leaves pointers and `count` unchanged.
- Pop: occurs only on the IDLE→WAIT transition; reads `mem[rd_ptr]` into `incoming_tag` and increments `rd_ptr`.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop on the same edge: unchanged.
- `tag_ready` depends only on `full`. When full, a same-edge pop does not allow a push; that tag is dropped and `overflow` is set.
- FSM, two states:
  - IDLE (`busy`=0): if `!empty`, pop; set `ena`<=1 and `busy`<=1; go to WAIT. Otherwise stay in IDLE with `ena`<=0. `tree_done` is ignored in IDLE.
  - WAIT (`busy`=1): `ena`<=0 on every edge. If `tree_done` is high, go to IDLE and set `busy`<=0; otherwise stay in WAIT.
- A `tree_done` sampled during the `ena` cycle is accepted, because that cycle is already WAIT.
- Reset values (asynchronous assertion, clears immediately):
  - `ena`=0, `incoming_tag`=0, `busy`=0, `count`=0, `overflow`=0.
  - Pointers = 0; state = IDLE.
  - Array contents are don't-care.
- Reset mid-operation: buffered tags are lost, and any in-flight `ena` drops immediately. Release is synchronous to `clk` as handled by the system reset synchronizer.

## Timing
- Push-to-issue latency on an empty, idle buffer:
  - Tag accepted at edge E0; `count`=1 after E0.
  - FSM pops at E1; `ena` and `incoming_tag` are valid in the cycle after E1.
  - So `ena` is high 2 cycles after `tag_valid` is first presented.
- `ena` is high for exactly one cycle per issued tag and is never asserted on consecutive cycles.
- Issue rate: with `ena` high after edge E1 and `tree_done` high at E2, the FSM is IDLE after E2 and the next `ena` follows E3. Minimum spacing is 2 cycles between `ena` pulses.
- `incoming_tag` changes only at edges that also raise `ena`.
- `count` and `busy` reflect the state after the most recent edge. `tag_ready` follows `count` combinationally.

## Test plan
- Reset, then a single push of tag 0x5A3 at E0: `ena`=1 with `incoming_tag`=0x5A3 after E1; `busy`=1; `count` returns to 0.
- Burst of 8 tags 0x001..0x008 back-to-back with `tree_done` held low: `count` reaches 8 minus pops (1 pop), and `tag_ready` drops when `count`=8. A 9th or later tag while full sets `overflow`; later `tree_done` pulses drain the tags in order 0x001.., with no 0x00A issued if it was dropped.
- `tree_done` pulsed in the same cycle `ena` is high, repeatedly, with 4 tags queued: `ena` pulses every 2 cycles; tags are issued in FIFO order.
- `tree_done` asserted while IDLE and empty: no state change, `ena` stays 0, `busy` stays 0.
- Push and pop on the same edge with `count`=3: `count` stays 3; pointer wrap is exercised over 20 tags with all issued in order.
- Assert `rst` low mid-WAIT with `count`=5: all outputs go to their reset values without a clock edge; after release a new tag 0xFFF is issued normally.

Source files
------------

// File: rtl/tag_issue_buffer.sv
// Tag FIFO feeding the sorter tree's input register: issues one tag per ena
// pulse and holds off further issues until the tree reports completion.
module tag_issue_buffer #(
  parameter int TAG_W  = 12,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tag_valid,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              tag_ready,
  input  logic              tree_done,
  output logic              ena,
  output logic [TAG_W-1:0]  incoming_tag,
  output logic              busy,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [TAG_W-1:0]   r_mem [DEPTH];
  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [ADDR_W-1:0]  r_rd_ptr;
  logic [ADDR_W:0]    r_count;
  logic               r_ena;
  logic [TAG_W-1:0]   r_tag;
  logic               r_overflow;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;

  assign w_full  = (r_count == (ADDR_W+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  // A pop freeing a slot on the same edge does not admit a push when full.
  assign w_push  = tag_valid && !w_full;

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tree_done) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_ena      <= 1'b0;
      r_tag      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ena   <= w_pop;
      if (w_pop) begin
        r_tag    <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (tag_valid && w_full) r_overflow <= 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; stale entries are never read past count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= tag_in;
  end

  assign tag_ready    = !w_full;
  assign ena          = r_ena;
  assign incoming_tag = r_tag;
  assign busy         = (r_state == S_WAIT);
  assign count        = r_count;
  assign overflow     = r_overflow;

endmodule
